wb_stage: RTL and testbench

Registered write-back stage for the pipelined RV core, replacing the combinational write-back select. It accepts one retiring instruction per cycle from the MEM stage and selects among ALU result, PC+4, load data and CSR read data. It also sign- or zero-extends and aligns sub-word loads, and drives the register-file write port one cycle later. It stalls MEM while a load response is outstanding and aborts the load if no response arrives within a bounded number of cycles.

---
 rtl/wb_stage.sv | 137 +++++++++++++
 tb/tb_wb_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// wb_stage: registered write-back select with load wait, timeout abort and optional load extension
//
// Optional feature macro: WB_LOAD_EXT_EN (sub-word load alignment and sign/zero extension).
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   MEM-stage handshake; in_ready is high only in IDLE
//   in_reg_wr, in_rd      write enable request and destination register
//   in_wb_sel             00 ALU, 01 PC+4, 10 load, 11 CSR
//   in_alu_res, in_pc,    candidate write-back sources
//   in_csr_rdata
//   in_funct3, in_addr_lo load type and byte offset (used only with WB_LOAD_EXT_EN)
//   dmem_rvalid/rdata     load response
//   rf_we/waddr/wdata     registered register-file write port
//   load_err              one-cycle pulse when a load response times out
module wb_stage #(
    parameter int XLEN = 32,
    parameter int TIMEOUT = 16,
    localparam int OFFW = $clog2(XLEN / 8)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_reg_wr,
    input  logic [4:0]      in_rd,
    input  logic [1:0]      in_wb_sel,
    input  logic [XLEN-1:0] in_alu_res,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_csr_rdata,
    input  logic [2:0]      in_funct3,
    input  logic [OFFW-1:0] in_addr_lo,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            load_err
);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT_LOAD = 1'b1;

    logic [0:0]      r_state;
    logic [CW-1:0]   r_cnt;
    logic [4:0]      r_rd;
    logic            r_reg_wr;
    logic            w_wait;
    logic [XLEN-1:0] w_load;
    logic [XLEN-1:0] w_sel;

    assign w_wait   = (r_state == WAIT_LOAD);
    assign in_ready = !w_wait;

`ifdef WB_LOAD_EXT_EN
    logic [2:0]      r_funct3;
    logic [OFFW-1:0] r_addr_lo;
    logic [2:0]      w_f3;
    logic [OFFW-1:0] w_lo;
    logic [XLEN-1:0] w_lane;

    // While waiting, the extension uses the load attributes captured at accept
    assign w_f3   = w_wait ? r_funct3 : in_funct3;
    assign w_lo   = w_wait ? r_addr_lo : in_addr_lo;
    assign w_lane = dmem_rdata >> {w_lo, 3'b000};

    always_comb begin
        case (w_f3)
            3'b000:  w_load = XLEN'($signed(w_lane[7:0]));
            3'b001:  w_load = XLEN'($signed(w_lane[15:0]));
            3'b100:  w_load = XLEN'(w_lane[7:0]);
            3'b101:  w_load = XLEN'(w_lane[15:0]);
            3'b010:  w_load = (XLEN == 64) ? XLEN'($signed(w_lane[31:0])) : dmem_rdata;
            3'b110:  w_load = (XLEN == 64) ? XLEN'(w_lane[31:0]) : dmem_rdata;
            default: w_load = dmem_rdata;
        endcase
    end
`else
    logic w_unused_ext;
    assign w_unused_ext = ^{in_funct3, in_addr_lo};
    assign w_load       = dmem_rdata;
`endif

    assign w_sel = (in_wb_sel == 2'b00) ? in_alu_res :
                   (in_wb_sel == 2'b01) ? in_pc + XLEN'(4) :
                   (in_wb_sel == 2'b10) ? w_load : in_csr_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_rd     <= '0;
            r_reg_wr <= 1'b0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            load_err <= 1'b0;
`ifdef WB_LOAD_EXT_EN
            r_funct3  <= '0;
            r_addr_lo <= '0;
`endif
        end else begin
            rf_we    <= 1'b0;
            load_err <= 1'b0;
            if (!w_wait) begin
                if (in_valid) begin
                    // A load whose data is already present retires like any other op
                    if (in_wb_sel != 2'b10 || dmem_rvalid) begin
                        rf_we    <= in_reg_wr && (in_rd != 5'd0);
                        rf_waddr <= in_rd;
                        rf_wdata <= w_sel;
                    end else begin
                        r_rd     <= in_rd;
                        r_reg_wr <= in_reg_wr;
                        r_cnt    <= '0;
                        r_state  <= WAIT_LOAD;
`ifdef WB_LOAD_EXT_EN
                        r_funct3  <= in_funct3;
                        r_addr_lo <= in_addr_lo;
`endif
                    end
                end
            end else if (dmem_rvalid) begin
                // Response beats timeout when both land in the same cycle
                rf_we    <= r_reg_wr && (r_rd != 5'd0);
                rf_waddr <= r_rd;
                rf_wdata <= w_load;
                r_state  <= IDLE;
            end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                load_err <= 1'b1;
                r_state  <= IDLE;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed self-checking bench for wb_stage (XLEN=32, TIMEOUT=4)
module tb_wb_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_reg_wr;
    logic [4:0]  in_rd;
    logic [1:0]  in_wb_sel;
    logic [31:0] in_alu_res;
    logic [31:0] in_pc;
    logic [31:0] in_csr_rdata;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addr_lo;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        load_err;
    int          n_chk = 0;
    int          n_err = 0;

    wb_stage #(.XLEN(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_reg_wr(in_reg_wr), .in_rd(in_rd), .in_wb_sel(in_wb_sel),
        .in_alu_res(in_alu_res), .in_pc(in_pc), .in_csr_rdata(in_csr_rdata),
        .in_funct3(in_funct3), .in_addr_lo(in_addr_lo), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] sel, input logic [4:0] rd,
                         input logic [2:0] f3, input logic [1:0] lo,
                         input logic rv, input logic [31:0] rdata);
        in_valid    = v;
        in_wb_sel   = sel;
        in_rd       = rd;
        in_reg_wr   = 1'b1;
        in_funct3   = f3;
        in_addr_lo  = lo;
        dmem_rvalid = rv;
        dmem_rdata  = rdata;
    endtask

    task automatic load_now(input string tag, input logic [2:0] f3, input logic [1:0] lo,
                            input logic [31:0] exp);
        drive(1'b1, 2'b10, 5'd6, f3, lo, 1'b1, 32'h0080FF00);
        tick();
        check({tag, "_we"}, 32'(rf_we), 32'd1);
        check({tag, "_wdata"}, rf_wdata, exp);
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n        = 1'b0;
        in_alu_res   = 32'h0;
        in_pc        = 32'h0;
        in_csr_rdata = 32'h0;
        drive(1'b0, 2'b00, 5'd0, 3'b0, 2'b0, 1'b0, 32'h0);
        repeat (2) tick();
        check("rst_we", 32'(rf_we), 32'd0);
        check("rst_waddr", 32'(rf_waddr), 32'd0);
        check("rst_wdata", rf_wdata, 32'd0);
        check("rst_err", 32'(load_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rst_ready", 32'(in_ready), 32'd1);

        in_alu_res = 32'h1234;
        drive(1'b1, 2'b00, 5'd5, 3'b0, 2'b0, 1'b0, 32'h0);
        tick();
        check("alu_we", 32'(rf_we), 32'd1);
        check("alu_waddr", 32'(rf_waddr), 32'd5);
        check("alu_wdata", rf_wdata, 32'h1234);
        drive(1'b0, 2'b00, 5'd5, 3'b0, 2'b0, 1'b1, 32'h0);
        tick();
        check("alu_pulse", 32'(rf_we), 32'd0);

        drive(1'b1, 2'b00, 5'd0, 3'b0, 2'b0, 1'b0, 32'h0);
        tick();
        check("rd0_we", 32'(rf_we), 32'd0);

        in_pc = 32'hFFFFFFFC;
        drive(1'b1, 2'b01, 5'd3, 3'b0, 2'b0, 1'b0, 32'h0);
        tick();
        check("pc4_we", 32'(rf_we), 32'd1);
        check("pc4_wdata", rf_wdata, 32'h0);

        in_csr_rdata = 32'hABCD;
        drive(1'b1, 2'b11, 5'd7, 3'b0, 2'b0, 1'b0, 32'h0);
        tick();
        check("csr_waddr", 32'(rf_waddr), 32'd7);
        check("csr_wdata", rf_wdata, 32'hABCD);

`ifdef WB_LOAD_EXT_EN
        load_now("lb", 3'b000, 2'd2, 32'hFFFFFF80);
        load_now("lbu", 3'b100, 2'd2, 32'h00000080);
        load_now("lhu", 3'b101, 2'd2, 32'h00000080);
        load_now("lh", 3'b001, 2'd1, 32'hFFFF80FF);
`else
        load_now("lb_raw", 3'b000, 2'd2, 32'h0080FF00);
        load_now("lhu_raw", 3'b101, 2'd2, 32'h0080FF00);
`endif

        // Delayed load: rvalid sampled on the third edge after accept, ALU op held behind it
        drive(1'b1, 2'b10, 5'd9, 3'b010, 2'b0, 1'b0, 32'h0);
        tick();
        in_alu_res = 32'h55;
        drive(1'b1, 2'b00, 5'd10, 3'b0, 2'b0, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("wait_ready%0d", i), 32'(in_ready), 32'd0);
            check($sformatf("wait_we%0d", i), 32'(rf_we), 32'd0);
            tick();
        end
        check("wait_ready2", 32'(in_ready), 32'd0);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hDEADBEEF;
        tick();
        dmem_rvalid = 1'b0;
        check("dly_we", 32'(rf_we), 32'd1);
        check("dly_waddr", 32'(rf_waddr), 32'd9);
        check("dly_wdata", rf_wdata, 32'hDEADBEEF);
        check("dly_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("held_we", 32'(rf_we), 32'd1);
        check("held_waddr", 32'(rf_waddr), 32'd10);
        check("held_wdata", rf_wdata, 32'h55);

        // Timeout with no response
        drive(1'b1, 2'b10, 5'd11, 3'b010, 2'b0, 1'b0, 32'h0);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("to_err%0d", i), 32'(load_err), 32'd0);
            tick();
        end
        check("to_err3", 32'(load_err), 32'd0);
        tick();
        check("to_err", 32'(load_err), 32'd1);
        check("to_we", 32'(rf_we), 32'd0);
        check("to_ready", 32'(in_ready), 32'd1);
        tick();
        check("to_pulse", 32'(load_err), 32'd0);

        // Response on the final waiting cycle wins over timeout
        drive(1'b1, 2'b10, 5'd12, 3'b010, 2'b0, 1'b0, 32'h0);
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h600DF00D;
        tick();
        dmem_rvalid = 1'b0;
        check("last_we", 32'(rf_we), 32'd1);
        check("last_wdata", rf_wdata, 32'h600DF00D);
        check("last_err", 32'(load_err), 32'd0);

        // Reset while waiting drops the load; a later stray rvalid writes nothing
        drive(1'b1, 2'b10, 5'd13, 3'b010, 2'b0, 1'b0, 32'h0);
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("wrst_we", 32'(rf_we), 32'd0);
        check("wrst_wdata", rf_wdata, 32'd0);
        check("wrst_err", 32'(load_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("wrst_ready", 32'(in_ready), 32'd1);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h12345678;
        tick();
        dmem_rvalid = 1'b0;
        check("stray_we", 32'(rf_we), 32'd0);
        check("stray_err", 32'(load_err), 32'd0);
        repeat (5) tick();
        check("idle_err", 32'(load_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
